// File: rtl/glb_rdfetch.sv
// glb_rdfetch: fetches CfgNum GLB words from CfgBaseAddr under a credit limit and
// serializes each returned word into RATIO narrower beats, LSB slice first.
module glb_rdfetch #(
    parameter int DATA_WIDTH = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CfgVld,
    output logic                  CfgRdy,
    input  logic [ADDR_WIDTH-1:0] CfgBaseAddr,
    input  logic [ADDR_WIDTH-1:0] CfgNum,
    output logic [ADDR_WIDTH-1:0] RdPortAddr,
    output logic                  RdPortAddrVld,
    input  logic                  RdPortAddrRdy,
    input  logic [DATA_WIDTH-1:0] RdPortDat,
    input  logic                  RdPortDatVld,
    output logic                  RdPortDatRdy,
    output logic [OUT_WIDTH-1:0]  OutDat,
    output logic                  OutVld,
    input  logic                  OutRdy,
    output logic                  OutLast
);
    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int BW    = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         num_q, num_d, issued_q, issued_d, words_q, words_d;
    logic [PW:0]           outst_q, outst_d, cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  cfg_acc, addr_acc, push, pop, last_slice, credit;

    always_comb begin
        // Credit only shrinks on an address handshake, so a stalled valid never drops.
        credit        = ({1'b0, outst_q} + {1'b0, cnt_q}) < (PW+2)'(FIFO_DEPTH);
        CfgRdy        = state_q == IDLE;
        RdPortAddrVld = state_q == FETCH && credit;
        RdPortAddr    = addr_q;
        RdPortDatRdy  = state_q != IDLE;
        OutVld        = cnt_q != '0;
        last_slice    = beat_q == BW'(RATIO - 1);
        OutDat        = OutVld ? mem_q[rptr_q][int'(beat_q)*OUT_WIDTH +: OUT_WIDTH] : '0;
        OutLast       = OutVld && last_slice && words_q == num_q - 1'b1;
        cfg_acc       = CfgVld && CfgRdy && CfgNum != '0;
        addr_acc      = RdPortAddrVld && RdPortAddrRdy;
        push          = RdPortDatVld && RdPortDatRdy;
        pop           = OutVld && OutRdy && last_slice;
        num_d         = cfg_acc ? {1'b0, CfgNum} : num_q;
        addr_d        = cfg_acc ? CfgBaseAddr : addr_acc ? addr_q + 1'b1 : addr_q;
        issued_d      = cfg_acc ? '0 : issued_q + CW'(addr_acc);
        words_d       = cfg_acc ? '0 : words_q + CW'(pop);
        outst_d       = outst_q + (PW+1)'(addr_acc) - (PW+1)'(push);
        cnt_d         = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        wptr_d        = wptr_q + PW'(push);
        rptr_d        = rptr_q + PW'(pop);
        beat_d        = (OutVld && OutRdy) ? (last_slice ? '0 : beat_q + 1'b1) : beat_q;
        state_d       = cfg_acc ? FETCH :
                        (state_q == FETCH && addr_acc && issued_q + 1'b1 == num_q) ? DRAIN :
                        (state_q == DRAIN && pop && OutLast) ? IDLE : state_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            words_q  <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            words_q  <= words_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            beat_q   <= beat_d;
        end
    end

    // Storage needs no reset: entries are only visible while cnt_q is nonzero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= RdPortDat;
    end
endmodule

// File: tb/tb_glb_rdfetch.sv
// tb_glb_rdfetch: directed checks of glb_rdfetch with a behavioural GLB and consumer.
module tb_glb_rdfetch;
    localparam int DW = 256, OW = 64, AW = 16;

    logic          clk = 0, rst_n = 0;
    logic          CfgVld = 0, CfgRdy;
    logic [AW-1:0] CfgBaseAddr = '0, CfgNum = '0;
    logic [AW-1:0] RdPortAddr;
    logic          RdPortAddrVld, RdPortAddrRdy = 1;
    logic [DW-1:0] RdPortDat = '0;
    logic          RdPortDatVld = 0, RdPortDatRdy;
    logic [OW-1:0] OutDat;
    logic          OutVld, OutRdy = 1, OutLast;

    glb_rdfetch dut (
        .clk(clk), .rst_n(rst_n), .CfgVld(CfgVld), .CfgRdy(CfgRdy),
        .CfgBaseAddr(CfgBaseAddr), .CfgNum(CfgNum),
        .RdPortAddr(RdPortAddr), .RdPortAddrVld(RdPortAddrVld), .RdPortAddrRdy(RdPortAddrRdy),
        .RdPortDat(RdPortDat), .RdPortDatVld(RdPortDatVld), .RdPortDatRdy(RdPortDatRdy),
        .OutDat(OutDat), .OutVld(OutVld), .OutRdy(OutRdy), .OutLast(OutLast)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0, n_bad = 0;
    logic [15:0]   tag = 16'h1111;
    bit            addr_rand = 0, out_rand = 0;
    logic          out_fix = 1;
    logic [AW-1:0] addr_log [$];
    logic [OW-1:0] beat_log [$];
    logic          last_log [$];
    logic [DW-1:0] pend [$];
    logic          prev_a_stall = 0, prev_o_stall = 0, last_flag = 0, prev_last = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [OW-1:0] prev_dat = '0;

    function automatic logic [DW-1:0] word_of(input logic [15:0] t, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) w[i*OW +: OW] = {t, a, 24'h0, 8'(i)};
        return w;
    endfunction

    function automatic logic [OW-1:0] exp_beat(input logic [15:0] t, input logic [AW-1:0] b, input int k);
        return {t, 16'(int'(b) + k / 4), 24'h0, 8'(k % 4)};
    endfunction

    // GLB responder, consumer and stall-stability monitor: sample at negedge, drive after posedge.
    always begin
        @(negedge clk);
        if (rst_n) begin
            prev_a_stall = 0;
            prev_o_stall = 0;
            last_flag    = 0;
        end else begin
            if (last_flag) begin
                n_cmp++;
                if (CfgRdy !== 1'b1) begin n_bad++; $display("FAIL idle_after_last: CfgRdy=%b want 1", CfgRdy); end
            end
            if (prev_a_stall) begin
                n_cmp++;
                if (RdPortAddrVld !== 1'b1 || RdPortAddr !== prev_addr) begin
                    n_bad++;
                    $display("FAIL addr_stable: vld=%b addr=%h want vld=1 addr=%h", RdPortAddrVld, RdPortAddr, prev_addr);
                end
            end
            if (prev_o_stall) begin
                n_cmp++;
                if (OutVld !== 1'b1 || OutDat !== prev_dat || OutLast !== prev_last) begin
                    n_bad++;
                    $display("FAIL out_stable: vld=%b dat=%h last=%b want vld=1 dat=%h last=%b", OutVld, OutDat, OutLast, prev_dat, prev_last);
                end
            end
            if (RdPortDatVld && RdPortDatRdy) void'(pend.pop_front());
            if (RdPortAddrVld && RdPortAddrRdy) begin
                addr_log.push_back(RdPortAddr);
                pend.push_back(word_of(tag, RdPortAddr));
            end
            if (OutVld && OutRdy) begin
                beat_log.push_back(OutDat);
                last_log.push_back(OutLast);
            end
            last_flag    = OutVld && OutRdy && OutLast;
            prev_a_stall = RdPortAddrVld && !RdPortAddrRdy;
            prev_addr    = RdPortAddr;
            prev_o_stall = OutVld && !OutRdy;
            prev_dat     = OutDat;
            prev_last    = OutLast;
        end
        @(posedge clk);
        #1;
        if (rst_n) pend.delete();
        RdPortDatVld = pend.size() > 0;
        if (pend.size() > 0) RdPortDat = pend[0];
        else RdPortDat = '0;
        RdPortAddrRdy = addr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        OutRdy = out_rand ? 1'($urandom_range(0, 1)) : out_fix;
    end

    task automatic clear_logs();
        addr_log.delete();
        beat_log.delete();
        last_log.delete();
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk);
        #2;
        CfgBaseAddr = b;
        CfgNum = n;
        CfgVld = 1;
        @(posedge clk);
        #2;
        CfgVld = 0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (CfgRdy) break;
        end
        n_cmp++;
        if (i == budget) begin n_bad++; $display("FAIL job_timeout: still busy after %0d cycles, want idle", budget); end
    endtask

    task automatic test_reset();
        #1 rst_n = 1;
        @(negedge clk);
        n_cmp += 7;
        if (CfgRdy !== 1'b1)        begin n_bad++; $display("FAIL rst_cfgrdy: %b want 1", CfgRdy); end
        if (RdPortAddrVld !== 1'b0) begin n_bad++; $display("FAIL rst_addrvld: %b want 0", RdPortAddrVld); end
        if (RdPortDatRdy !== 1'b0)  begin n_bad++; $display("FAIL rst_datrdy: %b want 0", RdPortDatRdy); end
        if (OutVld !== 1'b0)        begin n_bad++; $display("FAIL rst_outvld: %b want 0", OutVld); end
        if (OutLast !== 1'b0)       begin n_bad++; $display("FAIL rst_outlast: %b want 0", OutLast); end
        if (RdPortAddr !== '0)      begin n_bad++; $display("FAIL rst_addr: %h want 0", RdPortAddr); end
        if (OutDat !== '0)          begin n_bad++; $display("FAIL rst_outdat: %h want 0", OutDat); end
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_logs();
        tag = 16'hC0DE;
        start_job(16'h0010, 16'd3);
        wait_done(200);
        n_cmp++;
        if (addr_log.size() != 3) begin n_bad++; $display("FAIL basic_naddr: %0d want 3", addr_log.size()); end
        for (int k = 0; k < addr_log.size(); k++) begin
            n_cmp++;
            if (addr_log[k] !== 16'(16 + k)) begin n_bad++; $display("FAIL basic_addr[%0d]: %h want %h", k, addr_log[k], 16'(16 + k)); end
        end
        n_cmp++;
        if (beat_log.size() != 12) begin n_bad++; $display("FAIL basic_nbeat: %0d want 12", beat_log.size()); end
        for (int k = 0; k < beat_log.size(); k++) begin
            n_cmp++;
            if (beat_log[k] !== exp_beat(tag, 16'h0010, k) || last_log[k] !== (k == 11)) begin
                n_bad++;
                $display("FAIL basic_beat[%0d]: %h/%b want %h/%b", k, beat_log[k], last_log[k], exp_beat(tag, 16'h0010, k), k == 11);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        tag = 16'hB00B;
        out_fix = 0;
        start_job(16'h0100, 16'd8);
        repeat (30) @(negedge clk);
        n_cmp += 2;
        if (addr_log.size() != 4) begin n_bad++; $display("FAIL bp_credit_naddr: %0d want 4", addr_log.size()); end
        if (RdPortAddrVld !== 1'b0) begin n_bad++; $display("FAIL bp_addrvld: %b want 0", RdPortAddrVld); end
        out_fix = 1;
        wait_done(300);
        n_cmp += 2;
        if (addr_log.size() != 8) begin n_bad++; $display("FAIL bp_naddr: %0d want 8", addr_log.size()); end
        if (beat_log.size() != 32) begin n_bad++; $display("FAIL bp_nbeat: %0d want 32", beat_log.size()); end
        for (int k = 0; k < beat_log.size(); k++) begin
            n_cmp++;
            if (beat_log[k] !== exp_beat(tag, 16'h0100, k) || last_log[k] !== (k == 31)) begin
                n_bad++;
                $display("FAIL bp_beat[%0d]: %h/%b want %h/%b", k, beat_log[k], last_log[k], exp_beat(tag, 16'h0100, k), k == 31);
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want [4];
        want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clear_logs();
        tag = 16'hEEEE;
        start_job(16'hFFFE, 16'd4);
        wait_done(300);
        n_cmp += 2;
        if (addr_log.size() != 4) begin n_bad++; $display("FAIL wrap_naddr: %0d want 4", addr_log.size()); end
        if (beat_log.size() != 16) begin n_bad++; $display("FAIL wrap_nbeat: %0d want 16", beat_log.size()); end
        for (int k = 0; k < addr_log.size() && k < 4; k++) begin
            n_cmp++;
            if (addr_log[k] !== want[k]) begin n_bad++; $display("FAIL wrap_addr[%0d]: %h want %h", k, addr_log[k], want[k]); end
        end
        for (int k = 0; k < beat_log.size(); k++) begin
            n_cmp++;
            if (beat_log[k] !== exp_beat(tag, 16'hFFFE, k)) begin n_bad++; $display("FAIL wrap_beat[%0d]: %h want %h", k, beat_log[k], exp_beat(tag, 16'hFFFE, k)); end
        end
    endtask

    task automatic test_zero();
        clear_logs();
        start_job(16'h0500, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (RdPortAddrVld !== 1'b0 || OutVld !== 1'b0 || CfgRdy !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_idle[%0d]: addrvld=%b outvld=%b cfgrdy=%b want 0/0/1", i, RdPortAddrVld, OutVld, CfgRdy);
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        tag = 16'h5A5A;
        addr_rand = 1;
        out_rand = 1;
        start_job(16'h2000, 16'd20);
        wait_done(2000);
        addr_rand = 0;
        out_rand = 0;
        n_cmp++;
        if (beat_log.size() != 80) begin n_bad++; $display("FAIL rand_nbeat: %0d want 80", beat_log.size()); end
        for (int k = 0; k < beat_log.size(); k++) begin
            n_cmp++;
            if (beat_log[k] !== exp_beat(tag, 16'h2000, k) || last_log[k] !== (k == 79)) begin
                n_bad++;
                $display("FAIL rand_beat[%0d]: %h/%b want %h/%b", k, beat_log[k], last_log[k], exp_beat(tag, 16'h2000, k), k == 79);
            end
        end
    endtask

    task automatic test_mid_reset();
        int i;
        clear_logs();
        tag = 16'hAAAA;
        start_job(16'h0300, 16'd4);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (beat_log.size() >= 5) break;
        end
        n_cmp++;
        if (i == 200) begin n_bad++; $display("FAIL mr_wait5: %0d beats want 5", beat_log.size()); end
        @(posedge clk);
        #3 rst_n = 1;
        #1;
        n_cmp++;
        if (CfgRdy !== 1'b1 || RdPortAddrVld !== 1'b0 || RdPortDatRdy !== 1'b0 || OutVld !== 1'b0 ||
            OutLast !== 1'b0 || RdPortAddr !== '0 || OutDat !== '0) begin
            n_bad++;
            $display("FAIL mr_async: cfgrdy=%b avld=%b drdy=%b ovld=%b olast=%b addr=%h dat=%h want 1/0/0/0/0/0/0",
                     CfgRdy, RdPortAddrVld, RdPortDatRdy, OutVld, OutLast, RdPortAddr, OutDat);
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        clear_logs();
        @(negedge clk);
        n_cmp++;
        if (OutVld !== 1'b0 || CfgRdy !== 1'b1) begin n_bad++; $display("FAIL mr_after: outvld=%b cfgrdy=%b want 0/1", OutVld, CfgRdy); end
        tag = 16'hBBBB;
        start_job(16'h0400, 16'd1);
        wait_done(200);
        n_cmp += 2;
        if (addr_log.size() != 1) begin n_bad++; $display("FAIL mr_naddr: %0d want 1", addr_log.size()); end
        if (beat_log.size() != 4) begin n_bad++; $display("FAIL mr_nbeat: %0d want 4", beat_log.size()); end
        for (int k = 0; k < beat_log.size(); k++) begin
            n_cmp++;
            if (beat_log[k] !== exp_beat(tag, 16'h0400, k) || last_log[k] !== (k == 3)) begin
                n_bad++;
                $display("FAIL mr_beat[%0d]: %h/%b want %h/%b", k, beat_log[k], last_log[k], exp_beat(tag, 16'h0400, k), k == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_random();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/glb_rdfetch.md
GLB_RDFETCH -- requirements
Module: glb_rdfetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256, giving the GLB read-port data width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 64, giving the consumer beat width; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH, with RATIO = DATA_WIDTH/OUT_WIDTH.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 16, giving the GLB word address width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2, at least 2), giving the number of DATA_WIDTH entries in the return buffer.
REQ-005 The ports SHALL be:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (1 = reset).
- CfgVld  in  1  configuration request.
- CfgRdy  out  1  block idle; a configuration is accepted on CfgVld & CfgRdy.
- CfgBaseAddr  in  ADDR_WIDTH  first GLB word address.
- CfgNum  in  ADDR_WIDTH  number of GLB words to fetch.
- RdPortAddr  out  ADDR_WIDTH  read address to the GLB.
- RdPortAddrVld  out  1  address valid.
- RdPortAddrRdy  in  1  GLB accepts the address.
- RdPortDat  in  DATA_WIDTH  GLB read data.
- RdPortDatVld  in  1  read data valid.
- RdPortDatRdy  out  1  block accepts read data.
- OutDat  out  OUT_WIDTH  serialized beat.
- OutVld  out  1  beat valid.
- OutRdy  in  1  consumer accepts the beat.
- OutLast  out  1  final beat of the job; qualified by OutVld.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, FETCH and DRAIN; CfgRdy SHALL be 1 only in IDLE.
REQ-007 On acceptance of a configuration, the block SHALL latch CfgBaseAddr and CfgNum and go to FETCH; if CfgNum = 0 it SHALL remain in IDLE and produce no address and no output.
REQ-008 In FETCH, the block SHALL issue addresses base, base+1, ..., base+CfgNum-1, advancing only on RdPortAddrVld & RdPortAddrRdy; address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-009 RdPortAddrVld SHALL be asserted only when outstanding + fifo_count < FIFO_DEPTH, where outstanding = addresses accepted minus data words returned.
REQ-010 RdPortAddrVld and RdPortAddr SHALL be held stable while RdPortAddrRdy = 0, except that RdPortAddrVld may deassert only when the credit condition of REQ-009 fails.
REQ-011 After the last address is accepted, the FSM SHALL move to DRAIN.
REQ-012 In DRAIN, the FSM SHALL return to IDLE on the cycle after the final output handshake.
REQ-013 RdPortDatRdy SHALL be 1 in FETCH and DRAIN and 0 in IDLE; RdPortDatVld in IDLE SHALL be ignored.
REQ-014 Accepted read data SHALL be pushed into the FIFO; OutVld for that word SHALL assert no earlier than the next cycle (registered buffer, 1-cycle minimum latency).
REQ-015 The head FIFO entry SHALL be emitted as RATIO beats, least-significant OUT_WIDTH slice first; the beat index SHALL advance on OutVld & OutRdy, and the entry SHALL pop on the handshake of the last slice.
REQ-016 OutDat, OutVld and OutLast SHALL be held stable while OutVld = 1 and OutRdy = 0.
REQ-017 OutLast SHALL be 1 only on the final slice of word CfgNum-1.
REQ-018 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; an address acceptance and a data return in the same cycle SHALL leave outstanding unchanged.
REQ-019 The FIFO SHALL never overflow given REQ-009, and the counters SHALL be ADDR_WIDTH+1 bits wide so that CfgNum = 2^ADDR_WIDTH-1 completes correctly.
REQ-020 CfgVld while not in IDLE SHALL be ignored.

Reset
REQ-021 While rst_n = 1, asynchronously: FSM = IDLE; CfgRdy = 1; RdPortAddrVld = 0; RdPortDatRdy = 0; OutVld = 0; OutLast = 0; RdPortAddr = 0; OutDat = 0; all counters and FIFO pointers = 0.
REQ-022 Reset asserted mid-job SHALL abandon the job; after release the block SHALL be idle with an empty FIFO, and no stale beat SHALL be emitted.

Verification
REQ-023 Base 0x0010, Num 3, GLB rdy always 1, data 1 cycle after address, OutRdy = 1 -> addresses 0x10, 0x11, 0x12; 12 beats in order; OutLast on beat 12 only; CfgRdy = 1 the cycle after.
REQ-024 Num 8, OutRdy = 0 -> exactly 4 addresses accepted, then RdPortAddrVld = 0; releasing OutRdy yields 32 beats with no loss or duplication.
REQ-025 Base 0xFFFE, Num 4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-026 CfgNum = 0 -> no RdPortAddrVld and no OutVld, with CfgRdy remaining 1.
REQ-027 RdPortAddrRdy random at 50%, OutRdy random at 50%, Num 20 -> beats match the GLB data stream exactly, and the stable-while-stalled rules hold on both interfaces.
REQ-028 rst_n pulsed after 5 beats of a Num 4 job -> all outputs take their reset values immediately, and a following Num 1 job produces exactly 4 beats of new data.
